rr_sel4: RTL and testbench

- Round-robin selection stage that sits directly upstream of the 4-way 16-bit word mux.
- Arbitrates among four requesting word sources and drives the mux `sel` code. Holds the selection stable through a valid/ready handshake with the downstream consumer.
- Keeps a wrapping count of completed transfers for debug and bench checking.

---
 rtl/rr_sel4_if.sv | 30 +++
 rtl/rr_sel4.sv | 127 ++++++++++++
 tb/tb_rr_sel4.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_sel4_if.sv
// Handshake bundle between the round-robin selector and the word mux / downstream consumer.
// The master side is the selector; the slave side is the requesters plus the consumer.
interface rr_sel4_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       req;
  logic             out_ready;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic             out_valid;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output grant,
    output out_valid,
    output xfer_count
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  grant,
    input  out_valid,
    input  xfer_count
  );
endinterface

// File: rtl/rr_sel4.sv
// Round-robin selector for the 4-way word mux: holds sel/grant stable through a valid/ready
// handshake and counts completed transfers. All outputs come straight from flops.
module rr_sel4 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  rr_sel4_if.master  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       start;
  logic             win_found;
  logic [1:0]       win_idx;

  // First set bit of vec at or after start, wrapping 3->0; msb of result flags a hit.
  function automatic logic [2:0] pick(input logic [3:0] vec, input logic [1:0] from);
    logic       found;
    logic [1:0] idx;
    logic [1:0] probe;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      probe = from + 2'(k);
      if (!found && vec[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
    return {found, idx};
  endfunction

  // In BUSY the search starts after the word being served, since that becomes the new pointer.
  assign start = (state_q == StBusy) ? sel_q + 2'd1 : ptr_q + 2'd1;
  assign {win_found, win_idx} = pick(bus.req, start);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.out_ready && !win_found) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          sel_d   = win_idx;
          grant_d = 4'b0001 << win_idx;
          valid_d = 1'b1;
        end
      end
      StBusy: begin
        // Grant is never retracted; only acceptance moves anything.
        if (bus.out_ready) begin
          ptr_d = sel_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (win_found) begin
            sel_d   = win_idx;
            grant_d = 4'b0001 << win_idx;
            valid_d = 1'b1;
          end else begin
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.grant      = grant_q;
  assign bus.out_valid  = valid_q;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_rr_sel4.sv
// Bench for rr_sel4: directed vector table, counter-wrap sequence and random traffic against
// a behavioural round-robin model. A CNT_W=4 copy runs in lockstep for the wrap check.
module tb_rr_sel4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;

  int n_cmp;
  int n_err;

  rr_sel4_if #(.CNT_W(16)) bus0 ();
  rr_sel4_if #(.CNT_W(4))  bus1 ();

  assign bus0.req       = req;
  assign bus0.out_ready = out_ready;
  assign bus1.req       = req;
  assign bus1.out_ready = out_ready;

  rr_sel4 #(.CNT_W(16)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  rr_sel4 #(.CNT_W(4)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the word, who was served last, how many words went out.
  int m_valid;
  int m_sel;
  int m_last;
  int m_cnt;

  function automatic int winner(input logic [3:0] rq, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (rq[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic rdy);
    int w;
    if (r) begin
      m_valid = 0;
      m_sel   = 0;
      m_last  = 3;
      m_cnt   = 0;
    end else if (m_valid == 0) begin
      w = winner(rq, m_last);
      if (w >= 0) begin
        m_sel   = w;
        m_valid = 1;
      end
    end else if (rdy) begin
      m_last = m_sel;
      m_cnt  = m_cnt + 1;
      w = winner(rq, m_sel);
      if (w >= 0) m_sel = w;
      else m_valid = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive_step(input logic r, input logic [3:0] rq, input logic rdy);
    @(negedge clk);
    reset     = r;
    req       = rq;
    out_ready = rdy;
    model_step(r, rq, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] g;
    g = (m_valid != 0) ? (4'b0001 << m_sel) : 4'b0000;
    chk({tag, "_valid"}, 32'(bus0.out_valid), 32'(m_valid));
    chk({tag, "_sel"}, 32'(bus0.sel), 32'(m_sel));
    chk({tag, "_grant"}, 32'(bus0.grant), 32'(g));
    chk({tag, "_count"}, 32'(bus0.xfer_count), 32'(m_cnt % 65536));
    chk({tag, "_count4"}, 32'(bus1.xfer_count), 32'(m_cnt % 16));
    chk({tag, "_valid4"}, 32'(bus1.out_valid), 32'(m_valid));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       rdy;
    logic       v;
    logic [1:0] s;
    logic [3:0] g;
    int         c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic rdy,
                              input logic v, input logic [1:0] s, input logic [3:0] g,
                              input int c);
    vec_t x;
    x.rst = rst; x.rq = rq; x.rdy = rdy; x.v = v; x.s = s; x.g = g; x.c = c;
    return x;
  endfunction

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    m_valid   = 0;
    m_sel     = 0;
    m_last    = 3;
    m_cnt     = 0;

    // Idle after reset.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0));
    // All requesting, always ready: strict 0,1,2,3,0,1,2 with no bubble.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 1, 4'b0010, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 2, 4'b0100, 2));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 3, 4'b1000, 3));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 4'b0001, 4));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 1, 4'b0010, 5));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 2, 4'b0100, 6));
    // Backpressure on source 2, then accept with nobody requesting; IDLE ignores out_ready.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 4'b0100, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 2, 4'b0000, 1));
    // Grant held after the source drops its request.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 1, 1, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 1, 4'b0000, 1));
    // Lone requester re-granted back-to-back, then reset wins over a same-cycle accept.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 1, 3, 4'b1000, 1));
    tbl.push_back(mk(1, 4'b1000, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 1, 3, 4'b1000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i].rst, tbl[i].rq, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), 32'(bus0.out_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d_sel", i), 32'(bus0.sel), 32'(tbl[i].s));
      chk($sformatf("v%0d_grant", i), 32'(bus0.grant), 32'(tbl[i].g));
      chk($sformatf("v%0d_count", i), 32'(bus0.xfer_count), 32'(tbl[i].c));
      chk($sformatf("v%0d_count4", i), 32'(bus1.xfer_count), 32'(tbl[i].c % 16));
    end

    // Counter wrap on the 4-bit copy: 16 accepts of source 0.
    drive_step(1'b1, 4'b0000, 1'b0);
    check_model("wrap_rst");
    drive_step(1'b0, 4'b0001, 1'b1);
    check_model("wrap_grant");
    for (int i = 0; i < 16; i++) begin
      drive_step(1'b0, 4'b0001, 1'b1);
      check_model($sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d_sel4", i), 32'(bus1.sel), 32'd0);
    end
    chk("wrap_final_count4", 32'(bus1.xfer_count), 32'd0);
    chk("wrap_final_count16", 32'(bus0.xfer_count), 32'd16);

    // Random traffic against the model.
    drive_step(1'b1, 4'b0000, 1'b0);
    check_model("rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [3:0] rq;
      logic       rdy;
      r   = ($urandom_range(0, 99) == 0);
      rq  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 2) != 0);
      drive_step(r, rq, rdy);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
